spart_bus_arbiter: RTL and testbench
====================================

// Module: spart_bus_arbiter
// PURPOSE
//  Shares the single SPART register bus (iocs/iorw/ioaddr/databus) among
//  NUM_REQ requesters, such as the baud-config driver and a loopback/echo engine.
//  Round-robin arbitration; one SPART register access per grant.
//  Access to the TX/RX register (addr 00) is gated on tbr/rda, so a requester
//  that cannot proceed never blocks the others.
//  Illegal accesses are rejected without a bus cycle.
// PARAMETERS
//  NUM_REQ  2  number of requesters (2..8)
//  IDX_W    1  index width, = clog2(NUM_REQ)
// PORTS
//  clk        in     1          clock
//  rst        in     1          reset, synchronous, active-high
//  req_valid  in     NUM_REQ    request pending; hold until matching req_ack
//  req_rw     in     NUM_REQ    1=read, 0=write (per requester)
//  req_addr   in     2*NUM_REQ  SPART reg address, requester i at [2i+:2]
//  req_wdata  in     8*NUM_REQ  write data, requester i at [8i+:8]
//  req_ack    out    NUM_REQ    one-cycle completion pulse to winner
//  rsp_rdata  out    8          read data, valid while req_ack is high
//  rsp_err    out    1          1 with req_ack = illegal access, no bus cycle
//  rda        in     1          SPART receive data available
//  tbr        in     1          SPART transmit buffer ready
//  iocs       out    1          SPART chip select
//  iorw       out    1          1=read, 0=write
//  ioaddr     out    2          00 TX/RX, 01 status, 10 DB low, 11 DB high
//  databus    inout  8          driven with wdata only when iocs & ~iorw, else Z
// BEHAVIOUR
//  Reset: all outputs and state are registered.
//   - iocs=0, iorw=1, ioaddr=00, req_ack=0, rsp_rdata=0, rsp_err=0
//   - databus Z; state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
//   - Reset mid-transaction aborts it: no ack is issued and the bus is released the next cycle.
//  Eligibility of requester i, evaluated only in IDLE:
//   - valid & (addr!=00 | (rw ? rda : tbr)).
//   - Illegal: read of 10/11, write of 01. An illegal request is always eligible.
//  FSM: IDLE -> ISSUE -> DONE -> IDLE; an illegal request goes IDLE -> DONE.
//   IDLE:
//    - Winner = first eligible index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//    - Latch winner rw/addr/wdata; rr_ptr <= winner.
//    - No eligible requester: stay in IDLE, iocs=0.
//   ISSUE (exactly 1 cycle):
//    - iocs=1, iorw=latched rw, ioaddr=latched addr.
//    - On a write, databus=wdata.
//    - On a read, sample databus into rsp_rdata at the closing clock edge.
//   DONE (1 cycle):
//    - iocs=0, iorw=1, databus Z.
//    - req_ack[winner]=1; rsp_err=1 only for an illegal request.
//    - rsp_rdata holds the read value; it is 0 on a write or error.
//  Latency:
//   - Eligible in IDLE cycle t -> iocs at t+1 -> ack at t+2.
//   - Max throughput is 1 access per 3 cycles; an illegal request acks at t+1.
//  Boundaries and conflicts:
//   - rda/tbr changing during ISSUE/DONE is ignored; gating is sampled once.
//   - A requester that drops valid before ack is a protocol violation: the access still completes.
//   - Requesters must not reissue in the ack cycle; valid is sampled again only in IDLE.
//   - With all requesters valid and eligible, grants rotate 0,1,..,N-1,0; no starvation.
//   - A winner blocked on tbr/rda is skipped without moving rr_ptr past it.
//   - The bus is never driven in IDLE/DONE, which gives a turnaround cycle between accesses.
// TESTING
//  1. rst held 3 cycles, then released -> iocs=0, iorw=1, req_ack=0, databus Z.
//  2. req0 writes 0x15 to addr 10, then 0x05 to addr 11 ->
//     iocs at t+1 with ioaddr 10, databus 0x15; ack0 at t+2; repeat for addr 11.
//  3. req0 and req1 both continuously write addr 10 ->
//     grant order 0,1,0,1; each ack is 3 cycles apart.
//  4. req0 reads addr 00 with rda=0 and req1 writes addr 10 ->
//     req1 is served first; after rda=1 and the SPART drives 0xA5,
//     ack0 with rsp_rdata=0xA5.
//  5. req1 reads addr 11 -> ack1 one cycle later with rsp_err=1 and iocs never asserted.
//  6. rst asserted during ISSUE of a write -> no ack, iocs=0 and databus Z next cycle.

Source files
------------

// File: rtl/spart_bus_arbiter.sv
// Round-robin sharing of the SPART register bus; one register access per grant, illegal accesses rejected without a bus cycle.
// Eligible in IDLE at t -> iocs at t+1 -> req_ack at t+2 (illegal: ack at t+1); blocked TX/RX accesses wait in place without holding off others.
module spart_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [2*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    input  logic                   rda,
    input  logic                   tbr,
    output logic                   iocs,
    output logic                   iorw,
    output logic [1:0]             ioaddr,
    inout  wire  [7:0]             databus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_q;
    logic               rw_q;
    logic [7:0]         wdata_q;
    logic               drive_q;

    logic [NUM_REQ-1:0] illegal;
    logic [NUM_REQ-1:0] elig;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;
    logic               sel_rw;
    logic [1:0]         sel_addr;
    logic [7:0]         sel_wdata;
    logic               sel_illegal;

    // The TX/RX register is only offered to a requester when the SPART can take or give a byte.
    always_comb begin
        illegal = '0;
        elig    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            illegal[i] = req_rw[i] ? req_addr[2*i+1] : (req_addr[2*i +: 2] == 2'b01);
            elig[i]    = req_valid[i] &
                         (illegal[i] | (req_addr[2*i +: 2] != 2'b00) | (req_rw[i] ? rda : tbr));
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand     = (int'(rr_ptr) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && elig[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_rw      = 1'b1;
        sel_addr    = 2'b00;
        sel_wdata   = 8'h00;
        sel_illegal = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                sel_rw      = req_rw[i];
                sel_addr    = req_addr[2*i +: 2];
                sel_wdata   = req_wdata[8*i +: 8];
                sel_illegal = illegal[i];
            end
        end
    end

    // Only ISSUE of a write drives the bus, so IDLE/DONE give a turnaround cycle.
    assign databus = drive_q ? wdata_q : 8'hzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            win_q     <= '0;
            rw_q      <= 1'b1;
            wdata_q   <= 8'h00;
            drive_q   <= 1'b0;
            iocs      <= 1'b0;
            iorw      <= 1'b1;
            ioaddr    <= 2'b00;
            req_ack   <= '0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ack   <= '0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 8'h00;
                    if (win_found) begin
                        rr_ptr  <= win_idx;
                        win_q   <= win_idx;
                        rw_q    <= sel_rw;
                        wdata_q <= sel_wdata;
                        if (sel_illegal) begin
                            state   <= DONE;
                            req_ack <= NUM_REQ'(1) << win_idx;
                            rsp_err <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            iocs    <= 1'b1;
                            iorw    <= sel_rw;
                            ioaddr  <= sel_addr;
                            drive_q <= ~sel_rw;
                        end
                    end
                end
                ISSUE: begin
                    state     <= DONE;
                    iocs      <= 1'b0;
                    iorw      <= 1'b1;
                    drive_q   <= 1'b0;
                    req_ack   <= NUM_REQ'(1) << win_q;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= rw_q ? databus : 8'h00;
                end
                DONE: begin
                    state     <= IDLE;
                    req_ack   <= '0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 8'h00;
                end
                default: begin
                    state   <= IDLE;
                    iocs    <= 1'b0;
                    iorw    <= 1'b1;
                    drive_q <= 1'b0;
                    req_ack <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter with a tiny SPART read-data driver on the shared bus.
module tb_spart_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_rw = '0;
    logic [3:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0] req_ack;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rda = 1'b0;
    logic       tbr = 1'b1;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] spart_rd = 8'h00;
    logic [7:0] zz = 8'hzz;

    int n_checks = 0;
    int n_fail   = 0;

    assign databus = (iocs & iorw) ? spart_rd : 8'hzz;

    always #5 clk = ~clk;

    spart_bus_arbiter #(.NUM_REQ(2), .IDX_W(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rda       (rda),
        .tbr       (tbr),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_ack;

        // reset
        repeat (3) step();
        chk("rst_iocs", 16'(iocs), 16'd0);
        rst = 1'b0;
        step();
        chk("rel_iocs", 16'(iocs), 16'd0);
        chk("rel_iorw", 16'(iorw), 16'd1);
        chk("rel_ack", 16'(req_ack), 16'd0);
        chk("rel_bus", 16'(databus), 16'(zz));
        chk("rel_rdata", 16'(rsp_rdata), 16'd0);
        chk("rel_err", 16'(rsp_err), 16'd0);

        // two writes from requester 0
        req_valid = 2'b01; req_rw = 2'b00; req_addr = 4'b0010; req_wdata = 16'h0015;
        step();
        chk("w1_iocs", 16'(iocs), 16'd1);
        chk("w1_addr", 16'(ioaddr), 16'd2);
        chk("w1_iorw", 16'(iorw), 16'd0);
        chk("w1_bus", 16'(databus), 16'h15);
        chk("w1_noack", 16'(req_ack), 16'd0);
        step();
        chk("w1_ack", 16'(req_ack), 16'b01);
        chk("w1_err", 16'(rsp_err), 16'd0);
        chk("w1_iocs_off", 16'(iocs), 16'd0);
        chk("w1_bus_z", 16'(databus), 16'(zz));
        req_valid = 2'b00;
        step();
        req_valid = 2'b01; req_addr = 4'b0011; req_wdata = 16'h0005;
        step();
        chk("w2_iocs", 16'(iocs), 16'd1);
        chk("w2_addr", 16'(ioaddr), 16'd3);
        chk("w2_bus", 16'(databus), 16'h05);
        step();
        chk("w2_ack", 16'(req_ack), 16'b01);
        req_valid = 2'b00;
        step();

        // fresh pointer, then both requesters write continuously
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b11; req_rw = 2'b00; req_addr = 4'b1010; req_wdata = 16'h2211;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i % 3 == 2) exp_ack = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
            else            exp_ack = 2'b00;
            chk($sformatf("rr_ack_c%0d", i), 16'(req_ack), 16'(exp_ack));
            if (i == 4) chk("rr_bus_req1", 16'(databus), 16'h22);
        end
        req_valid = 2'b00;

        // req0 read of RX blocked on rda, req1 served first
        req_valid = 2'b11; req_rw = 2'b01; req_addr = 4'b1000; req_wdata = 16'h3C00;
        rda = 1'b0; spart_rd = 8'hA5;
        step();
        chk("blk_iocs", 16'(iocs), 16'd1);
        chk("blk_addr", 16'(ioaddr), 16'd2);
        chk("blk_bus", 16'(databus), 16'h3C);
        step();
        chk("blk_ack1", 16'(req_ack), 16'b10);
        req_valid = 2'b01;
        step();
        chk("blk_wait1", 16'(iocs), 16'd0);
        step();
        chk("blk_wait2", 16'(iocs), 16'd0);
        chk("blk_wait_ack", 16'(req_ack), 16'd0);
        rda = 1'b1;
        step();
        chk("rd_iocs", 16'(iocs), 16'd1);
        chk("rd_iorw", 16'(iorw), 16'd1);
        chk("rd_addr", 16'(ioaddr), 16'd0);
        chk("rd_bus", 16'(databus), 16'hA5);
        rda = 1'b0;
        step();
        chk("rd_ack0", 16'(req_ack), 16'b01);
        chk("rd_data", 16'(rsp_rdata), 16'hA5);
        chk("rd_err", 16'(rsp_err), 16'd0);
        req_valid = 2'b00;
        step();
        chk("rd_data_clr", 16'(rsp_rdata), 16'd0);

        // illegal read of DB high from req1
        req_valid = 2'b10; req_rw = 2'b10; req_addr = 4'b1100;
        step();
        chk("ill_ack", 16'(req_ack), 16'b10);
        chk("ill_err", 16'(rsp_err), 16'd1);
        chk("ill_iocs", 16'(iocs), 16'd0);
        chk("ill_rdata", 16'(rsp_rdata), 16'd0);
        req_valid = 2'b00;
        step();
        chk("ill_ack_off", 16'(req_ack), 16'd0);
        chk("ill_err_off", 16'(rsp_err), 16'd0);
        chk("ill_iocs2", 16'(iocs), 16'd0);

        // reset during ISSUE of a write
        req_valid = 2'b01; req_rw = 2'b00; req_addr = 4'b0010; req_wdata = 16'h0077;
        step();
        chk("ab_iocs", 16'(iocs), 16'd1);
        chk("ab_bus", 16'(databus), 16'h77);
        rst = 1'b1;
        step();
        chk("ab_iocs_off", 16'(iocs), 16'd0);
        chk("ab_bus_z", 16'(databus), 16'(zz));
        chk("ab_noack", 16'(req_ack), 16'd0);
        rst = 1'b0; req_valid = 2'b00;
        step();
        chk("ab_noack2", 16'(req_ack), 16'd0);
        chk("ab_iocs2", 16'(iocs), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
